if_stage: RTL

Instruction-fetch stage of the 16-bit pipelined CPU. Owns the program counter, drives the combinational instruction memory address, and latches the returned word into the IF/ID pipeline register. Handles load-use stalls, branch redirect with flush of the wrong-path fetch, and HALT detection. Sits directly upstream of the decode stage.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_stage.sv | 97 +++++++++
 2 files changed

// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared instruction-encoding definitions for the 16-bit pipelined CPU.
// Holds the opcode field position, the HALT opcode and the NOP word, plus a
// small helper that classifies a fetched word as HALT.
// No ports (package).
// ---------------------------------------------------------------------------
package if_stage_pkg;

    // Opcode lives in the top five bits of every instruction word.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;

    localparam logic [4:0]  OPC_HALT  = 5'b11111;
    localparam logic [15:0] INSTR_NOP = 16'h0000;

    // True when the word carries the HALT opcode, whatever its operand bits.
    function automatic logic is_halt(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB] == OPC_HALT;
    endfunction

endpackage

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Owns the program counter, presents it to the
// combinational instruction memory and captures the returned word into the
// IF/ID pipeline register. Handles load-use stalls, branch redirect (with the
// wrong-path fetch squashed to a bubble) and HALT detection.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset
//   enable         in   global run enable, low freezes every register
//   stall          in   hold PC and IF/ID (load-use hazard from decode)
//   branch_taken   in   redirect request from execute
//   branch_target  in   redirect address
//   pc_out         out  instruction memory address (the PC register)
//   imem_data      in   word returned by instruction memory, same cycle
//   id_ir          out  IF/ID instruction register
//   id_pc          out  address of the instruction in id_ir, plus 1
//   id_valid       out  id_ir holds a real fetched instruction
//   halted         out  fetch stopped on HALT
// ---------------------------------------------------------------------------
import if_stage_pkg::*;

module if_stage #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] id_ir,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               id_valid,
    output logic               halted
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              fetch_halt;

    // Increment wraps naturally at 2^ADDR_W; no overflow flag is kept.
    assign pc_inc     = pc + ADDR_W'(1);
    assign fetch_halt = is_halt(imem_data);
    assign pc_out     = pc;

    // Program counter. A branch overrides stall and halt; a freshly fetched
    // HALT parks the PC on its own address so the HALT word is not re-read
    // as a new instruction stream beyond it.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= '0;
        end else if (enable) begin
            if (branch_taken) begin
                pc <= branch_target;
            end else if (!stall && !halted && !fetch_halt) begin
                pc <= pc_inc;
            end
        end
    end

    // IF/ID register and halt flag. The branch case squashes the wrong-path
    // word into a bubble and cancels any speculative HALT; id_pc is left as
    // is for bubbles because id_valid already marks them as meaningless.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_ir    <= INSTR_NOP;
            id_pc    <= '0;
            id_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (enable) begin
            if (branch_taken) begin
                id_ir    <= INSTR_NOP;
                id_valid <= 1'b0;
                halted   <= 1'b0;
            end else if (stall) begin
                id_ir    <= id_ir;
                id_valid <= id_valid;
            end else if (halted) begin
                id_ir    <= INSTR_NOP;
                id_valid <= 1'b0;
            end else begin
                id_ir    <= imem_data;
                id_pc    <= pc_inc;
                id_valid <= 1'b1;
                if (fetch_halt) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule
